// File: rtl/exception_ctrl_if.sv
// Pipeline-side bundle for the M-stage exception resolver: M-stage status in,
// CP0 commit / flush / redirect controls out.
interface exception_ctrl_if #(
  parameter int N_EXT_INT = 6
);
  logic [N_EXT_INT-1:0] ext_int;
  logic                 timer_int;
  logic                 valid_m;
  logic                 stall_m;
  logic                 bd_m;
  logic [31:0]          pc_m;
  logic [31:0]          aluout_m;
  logic                 ri;
  logic                 brk;
  logic                 sys;
  logic                 ov;
  logic                 tr;
  logic                 adel_if;
  logic                 adel_ld;
  logic                 ades;
  logic                 eret_m;
  logic [31:0]          cp0_status;
  logic [31:0]          cp0_cause;
  logic [31:0]          cp0_epc;

  logic                 exc_valid;
  logic [4:0]           exc_code;
  logic                 exc_bd;
  logic [31:0]          exc_epc;
  logic                 badvaddr_we;
  logic [31:0]          badvaddr;
  logic                 eret_valid;
  logic                 flush;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 busy;

  modport master (
    output ext_int, timer_int, valid_m, stall_m, bd_m, pc_m, aluout_m,
           ri, brk, sys, ov, tr, adel_if, adel_ld, ades, eret_m,
           cp0_status, cp0_cause, cp0_epc,
    input  exc_valid, exc_code, exc_bd, exc_epc, badvaddr_we, badvaddr,
           eret_valid, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  ext_int, timer_int, valid_m, stall_m, bd_m, pc_m, aluout_m,
           ri, brk, sys, ov, tr, adel_if, adel_ld, ades, eret_m,
           cp0_status, cp0_cause, cp0_epc,
    output exc_valid, exc_code, exc_bd, exc_epc, badvaddr_we, badvaddr,
           eret_valid, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exception_ctrl.sv
// M-stage exception resolver: synchronises interrupts, picks the winning
// exception or eret, pulses the CP0 commit and redirect, and holds flush.
module exception_ctrl #(
  parameter int          N_EXT_INT    = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380
) (
  input  logic             clk,
  input  logic             rst,
  exception_ctrl_if.slave  bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [N_EXT_INT-1:0] sync_reg [SYNC_STAGES];

  logic        exc_valid_reg, exc_valid_next;
  logic [4:0]  exc_code_reg, exc_code_next;
  logic        exc_bd_reg, exc_bd_next;
  logic [31:0] exc_epc_reg, exc_epc_next;
  logic        badvaddr_we_reg, badvaddr_we_next;
  logic [31:0] badvaddr_reg, badvaddr_next;
  logic        eret_valid_reg, eret_valid_next;
  logic        redirect_valid_reg, redirect_valid_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;

  logic [N_EXT_INT-1:0] int_sync;
  logic                 int_req;
  logic                 is_exc;
  logic                 trig;
  logic [4:0]           win_code;
  logic                 win_bv_we;
  logic                 win_bv_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= bus.ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign int_sync = sync_reg[SYNC_STAGES-1];

  // IE=bit0, EXL=bit1; timer is gated by IM[15] in addition to the hardware mask.
  assign int_req = bus.cp0_status[0] & ~bus.cp0_status[1] &
                   ( (|(bus.cp0_status[9:8] & bus.cp0_cause[9:8]))
                   | (|(bus.cp0_status[10 +: N_EXT_INT] & int_sync))
                   | (bus.cp0_status[15] & bus.timer_int) );

  assign is_exc = int_req | bus.adel_if | bus.ri | bus.sys | bus.brk |
                  bus.adel_ld | bus.ades | bus.ov | bus.tr;

  assign trig = bus.valid_m & ~bus.stall_m & (state_reg == IDLE) & (is_exc | bus.eret_m);

  always_comb begin
    win_code  = 5'd0;
    win_bv_we = 1'b0;
    win_bv_pc = 1'b0;
    if (int_req)          win_code = 5'd0;
    else if (bus.adel_if) begin win_code = 5'd4; win_bv_we = 1'b1; win_bv_pc = 1'b1; end
    else if (bus.ri)      win_code = 5'd10;
    else if (bus.sys)     win_code = 5'd8;
    else if (bus.brk)     win_code = 5'd9;
    else if (bus.adel_ld) begin win_code = 5'd4; win_bv_we = 1'b1; end
    else if (bus.ades)    begin win_code = 5'd5; win_bv_we = 1'b1; end
    else if (bus.ov)      win_code = 5'd12;
    else if (bus.tr)      win_code = 5'd13;
  end

  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    exc_valid_next      = 1'b0;
    exc_code_next       = 5'd0;
    exc_bd_next         = 1'b0;
    exc_epc_next        = 32'd0;
    badvaddr_we_next    = 1'b0;
    badvaddr_next       = 32'd0;
    eret_valid_next     = 1'b0;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = 32'd0;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          state_next          = FLUSH;
          cnt_next            = CNT_W'(FLUSH_CYCLES - 1);
          redirect_valid_next = 1'b1;
          // An exception in the same cycle as eret always wins.
          if (is_exc) begin
            exc_valid_next   = 1'b1;
            exc_code_next    = win_code;
            exc_bd_next      = bus.bd_m;
            exc_epc_next     = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
            badvaddr_we_next = win_bv_we;
            badvaddr_next    = win_bv_pc ? bus.pc_m : bus.aluout_m;
            redirect_pc_next = EXC_VECTOR;
          end else begin
            eret_valid_next  = 1'b1;
            redirect_pc_next = bus.cp0_epc;
          end
        end
      end
      FLUSH: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      exc_valid_reg      <= 1'b0;
      exc_code_reg       <= 5'd0;
      exc_bd_reg         <= 1'b0;
      exc_epc_reg        <= 32'd0;
      badvaddr_we_reg    <= 1'b0;
      badvaddr_reg       <= 32'd0;
      eret_valid_reg     <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= 32'd0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      exc_valid_reg      <= exc_valid_next;
      exc_code_reg       <= exc_code_next;
      exc_bd_reg         <= exc_bd_next;
      exc_epc_reg        <= exc_epc_next;
      badvaddr_we_reg    <= badvaddr_we_next;
      badvaddr_reg       <= badvaddr_next;
      eret_valid_reg     <= eret_valid_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
    end
  end

  assign bus.exc_valid      = exc_valid_reg;
  assign bus.exc_code       = exc_code_reg;
  assign bus.exc_bd         = exc_bd_reg;
  assign bus.exc_epc        = exc_epc_reg;
  assign bus.badvaddr_we    = badvaddr_we_reg;
  assign bus.badvaddr       = badvaddr_reg;
  assign bus.eret_valid     = eret_valid_reg;
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.flush          = (state_reg == FLUSH);
  assign bus.busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: a vector table for single-event
// resolution plus hand sequences for sync latency, flush window, stall, reset.
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'hbfc00380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exception_ctrl_if #(.N_EXT_INT(6)) bus ();

  exception_ctrl #(
    .N_EXT_INT   (6),
    .SYNC_STAGES (2),
    .FLUSH_CYCLES(3),
    .EXC_VECTOR  (VEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // flags: [0]ri [1]brk [2]sys [3]ov [4]tr [5]adel_if [6]adel_ld [7]ades [8]eret [9]timer
  typedef struct {
    logic [9:0]  flags;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        e_exc;
    logic [4:0]  e_code;
    logic [31:0] e_epc;
    logic        e_bvwe;
    logic [31:0] e_bv;
    logic        e_eret;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_flags(input logic [9:0] f);
    bus.ri = f[0]; bus.brk = f[1]; bus.sys = f[2]; bus.ov = f[3]; bus.tr = f[4];
    bus.adel_if = f[5]; bus.adel_ld = f[6]; bus.ades = f[7]; bus.eret_m = f[8];
    bus.timer_int = f[9];
  endtask

  task automatic clear_inputs();
    set_flags(10'd0);
    bus.ext_int = '0; bus.valid_m = 1'b0; bus.stall_m = 1'b0; bus.bd_m = 1'b0;
    bus.pc_m = 32'd0; bus.aluout_m = 32'd0;
    bus.cp0_status = 32'h0000ff01; bus.cp0_cause = 32'd0; bus.cp0_epc = 32'd0;
  endtask

  task automatic set_vec(input int i, input logic [9:0] f, input logic bd, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] st, input logic [31:0] ca,
                         input logic [31:0] ep, input logic ex, input logic [4:0] code,
                         input logic [31:0] eepc, input logic bvwe, input logic [31:0] bv,
                         input logic er, input logic [31:0] rpc);
    vecs[i] = '{f, bd, pc, alu, st, ca, ep, ex, code, eepc, bvwe, bv, er, rpc};
  endtask

  initial begin
    // Sync exceptions run with no pending interrupt sources.
    set_vec(0,  10'h004, 0, 32'h80000010, 32'h0,    32'h0000ff01, 0, 0, 1, 8,  32'h80000010, 0, 0, 0, VEC);
    set_vec(1,  10'h048, 1, 32'h80000020, 32'h1003, 32'h0000ff01, 0, 0, 1, 4,  32'h8000001c, 1, 32'h1003, 0, VEC);
    set_vec(2,  10'h100, 0, 32'h80000030, 32'h0,    32'h0000ff01, 0, 32'h80000100, 0, 0, 0, 0, 0, 1, 32'h80000100);
    set_vec(3,  10'h101, 0, 32'h80000030, 32'h0,    32'h0000ff01, 0, 32'h80000100, 1, 10, 32'h80000030, 0, 0, 0, VEC);
    set_vec(4,  10'h021, 0, 32'h80000040, 32'h1234, 32'h0000ff01, 0, 0, 1, 4,  32'h80000040, 1, 32'h80000040, 0, VEC);
    set_vec(5,  10'h006, 0, 32'h80000050, 32'h0,    32'h0000ff01, 0, 0, 1, 8,  32'h80000050, 0, 0, 0, VEC);
    set_vec(6,  10'h042, 0, 32'h80000060, 32'h7,    32'h0000ff01, 0, 0, 1, 9,  32'h80000060, 0, 0, 0, VEC);
    set_vec(7,  10'h088, 1, 32'h80000070, 32'h2002, 32'h0000ff01, 0, 0, 1, 5,  32'h8000006c, 1, 32'h2002, 0, VEC);
    set_vec(8,  10'h010, 0, 32'h80000080, 32'h0,    32'h0000ff01, 0, 0, 1, 13, 32'h80000080, 0, 0, 0, VEC);
    set_vec(9,  10'h018, 0, 32'h80000090, 32'h0,    32'h0000ff01, 0, 0, 1, 12, 32'h80000090, 0, 0, 0, VEC);
    set_vec(10, 10'h001, 1, 32'h80000000, 32'h0,    32'h00000101, 32'h100, 0, 1, 0, 32'h7ffffffc, 0, 0, 0, VEC);
    set_vec(11, 10'h280, 0, 32'h800000a0, 32'h44,   32'h00008001, 0, 0, 1, 0,  32'h800000a0, 0, 0, 0, VEC);
    set_vec(12, 10'h200, 0, 32'h800000b0, 32'h0,    32'h00008003, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    set_vec(13, 10'h004, 1, 32'h00000000, 32'h0,    32'h0000ff01, 0, 0, 1, 8,  32'hfffffffc, 0, 0, 0, VEC);

    clear_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_exc_valid", 32'(bus.exc_valid), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_eret_valid", 32'(bus.eret_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: one trigger, outputs one edge later, then let flush drain.
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      set_flags(vecs[i].flags);
      bus.valid_m = 1'b1; bus.bd_m = vecs[i].bd; bus.pc_m = vecs[i].pc;
      bus.aluout_m = vecs[i].alu; bus.cp0_status = vecs[i].status;
      bus.cp0_cause = vecs[i].cause; bus.cp0_epc = vecs[i].epc;
      @(negedge clk);
      chk($sformatf("v%0d_exc_valid", i), 32'(bus.exc_valid), 32'(vecs[i].e_exc));
      chk($sformatf("v%0d_eret_valid", i), 32'(bus.eret_valid), 32'(vecs[i].e_eret));
      chk($sformatf("v%0d_redirect_valid", i), 32'(bus.redirect_valid), 32'(vecs[i].e_exc | vecs[i].e_eret));
      chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].e_exc | vecs[i].e_eret));
      if (vecs[i].e_exc | vecs[i].e_eret)
        chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
      if (vecs[i].e_exc) begin
        chk($sformatf("v%0d_exc_code", i), 32'(bus.exc_code), 32'(vecs[i].e_code));
        chk($sformatf("v%0d_exc_bd", i), 32'(bus.exc_bd), 32'(vecs[i].bd));
        chk($sformatf("v%0d_exc_epc", i), bus.exc_epc, vecs[i].e_epc);
        chk($sformatf("v%0d_badvaddr_we", i), 32'(bus.badvaddr_we), 32'(vecs[i].e_bvwe));
        if (vecs[i].e_bvwe)
          chk($sformatf("v%0d_badvaddr", i), bus.badvaddr, vecs[i].e_bv);
      end
      clear_inputs();
      repeat (4) @(negedge clk);
    end

    // External interrupt latency through the 2-flop synchroniser.
    clear_inputs();
    bus.cp0_status = 32'h00001001; bus.valid_m = 1'b1; bus.pc_m = 32'h80000200;
    bus.ext_int = 6'b000100;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("extint_c%0d_exc_valid", k), 32'(bus.exc_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("extint_exc_code", 32'(bus.exc_code), 0);
    chk("extint_redirect_pc", bus.redirect_pc, VEC);
    clear_inputs();
    repeat (5) @(negedge clk);

    // EXL set masks the interrupt.
    bus.cp0_status = 32'h00001003; bus.valid_m = 1'b1; bus.ext_int = 6'b000100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("exl_c%0d_busy", k), 32'(bus.busy), 0);
    end
    clear_inputs();
    repeat (4) @(negedge clk);

    // Flush window of 3 ignores a retrigger; held interrupt taken on first IDLE cycle.
    bus.cp0_status = 32'h00000101; bus.valid_m = 1'b1; bus.sys = 1'b1; bus.pc_m = 32'h80000300;
    @(negedge clk);
    chk("fl_c1_exc_valid", 32'(bus.exc_valid), 1);
    chk("fl_c1_flush", 32'(bus.flush), 1);
    bus.cp0_cause = 32'h00000100;
    @(negedge clk);
    chk("fl_c2_exc_valid", 32'(bus.exc_valid), 0);
    chk("fl_c2_flush", 32'(bus.flush), 1);
    @(negedge clk);
    chk("fl_c3_exc_valid", 32'(bus.exc_valid), 0);
    chk("fl_c3_flush", 32'(bus.flush), 1);
    @(negedge clk);
    chk("fl_c4_flush", 32'(bus.flush), 0);
    chk("fl_c4_exc_valid", 32'(bus.exc_valid), 0);
    @(negedge clk);
    chk("fl_c5_exc_valid", 32'(bus.exc_valid), 1);
    chk("fl_c5_exc_code", 32'(bus.exc_code), 0);
    clear_inputs();
    repeat (4) @(negedge clk);

    // Stall blocks the trigger until it drops, then reset mid-flush.
    bus.valid_m = 1'b1; bus.sys = 1'b1; bus.stall_m = 1'b1; bus.pc_m = 32'h80000400;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d_exc_valid", k), 32'(bus.exc_valid), 0);
    end
    bus.stall_m = 1'b0;
    @(negedge clk);
    chk("stall_release_exc_valid", 32'(bus.exc_valid), 1);
    chk("stall_release_exc_code", 32'(bus.exc_code), 8);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_flush", 32'(bus.flush), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_exc_valid", 32'(bus.exc_valid), 0);
    chk("midrst_redirect_valid", 32'(bus.redirect_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
